// File: rtl/intr_ctrl.sv
// intr_ctrl: MCU interrupt controller.
// Synchronizes and edge-detects external requests into pending bits, runs the
// request/ack/return handshake with the control unit, and keeps the interrupt
// enable flag plus the C/Z shadow copies saved on ISR entry.
module intr_ctrl #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               sei,
   input  logic               cli,
   input  logic               int_ack,
   input  logic               retie,
   input  logic               c_in,
   input  logic               z_in,
   output logic               intr,
   output logic               int_en,
   output logic [ID_W-1:0]    src_id,
   output logic [NUM_SRC-1:0] pending,
   output logic               shad_c,
   output logic               shad_z,
   output logic               restore
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      IN_ISR = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_SRC-1:0] sync1;
   logic [NUM_SRC-1:0] sync2;
   logic [NUM_SRC-1:0] prev;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] ack_mask;
   logic [ID_W-1:0]    ack_id;

   // A request counts once per low-to-high transition of the synchronized input.
   assign rise = sync2 & ~prev;

   // Fixed priority pick of the pending source to service: bit 0 wins.
   always_comb begin
      ack_id   = '0;
      ack_mask = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            ack_id      = ID_W'(i);
            ack_mask    = '0;
            ack_mask[i] = 1'b1;
         end
      end
   end

   // Capture, enable flag and request/ack/return state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         prev    <= '0;
         pending <= '0;
         state   <= IDLE;
         intr    <= 1'b0;
         int_en  <= 1'b0;
         src_id  <= '0;
         shad_c  <= 1'b0;
         shad_z  <= 1'b0;
         restore <= 1'b0;
      end else begin
         sync1   <= irq_in;
         sync2   <= sync1;
         prev    <= sync2;
         restore <= 1'b0;
         pending <= pending | rise;

         // cli dominates sei; the state machine below may override this
         if (cli) begin
            int_en <= 1'b0;
         end else if (sei) begin
            int_en <= 1'b1;
         end

         case (state)
            IDLE: begin
               intr <= 1'b0;
               if (int_en && (pending != '0)) begin
                  state <= REQ;
                  intr  <= 1'b1;
               end
            end
            REQ: begin
               if (int_ack) begin
                  // a fresh edge on the serviced bit keeps it pending
                  src_id  <= ack_id;
                  pending <= (pending & ~ack_mask) | rise;
                  shad_c  <= c_in;
                  shad_z  <= z_in;
                  int_en  <= 1'b0;
                  intr    <= 1'b0;
                  state   <= IN_ISR;
               end else if (cli) begin
                  intr  <= 1'b0;
                  state <= IDLE;
               end else begin
                  intr <= 1'b1;
               end
            end
            IN_ISR: begin
               intr <= 1'b0;
               if (retie) begin
                  int_en  <= 1'b1;
                  restore <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               intr  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus randomized traffic for intr_ctrl,
// checked against a transaction-level reference model.
module tb_intr_ctrl;

   localparam int unsigned N    = 4;
   localparam int unsigned ID_W = 2;
   localparam int unsigned VW   = N + ID_W + 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  irq_in = '0;
   logic          sei = 1'b0, cli = 1'b0, int_ack = 1'b0, retie = 1'b0;
   logic          c_in = 1'b0, z_in = 1'b0;
   logic          intr, int_en, shad_c, shad_z, restore;
   logic [ID_W-1:0] src_id;
   logic [N-1:0]  pending;

   int checks = 0;
   int errors = 0;

   // reference model: sample history and abstract handshake phase
   logic [N-1:0]    h1 = '0, h2 = '0, h3 = '0;
   logic [N-1:0]    m_pend = '0;
   int              m_phase = 0;   // 0 waiting, 1 requesting, 2 servicing
   logic            m_en = 1'b0, m_intr = 1'b0, m_sc = 1'b0, m_sz = 1'b0, m_rest = 1'b0;
   logic [ID_W-1:0] m_id = '0;

   intr_ctrl #(.NUM_SRC(N), .ID_W(ID_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .irq_in  (irq_in),
      .sei     (sei),
      .cli     (cli),
      .int_ack (int_ack),
      .retie   (retie),
      .c_in    (c_in),
      .z_in    (z_in),
      .intr    (intr),
      .int_en  (int_en),
      .src_id  (src_id),
      .pending (pending),
      .shad_c  (shad_c),
      .shad_z  (shad_z),
      .restore (restore)
   );

   always #5 clk = ~clk;

   // One clock edge of the reference model, using the inputs present at that edge.
   task automatic model_step();
      logic [N-1:0] rise, op;
      logic         oen;
      int           ph, i;
      if (rst) begin
         h1 = '0; h2 = '0; h3 = '0; m_pend = '0; m_phase = 0;
         m_en = 0; m_intr = 0; m_sc = 0; m_sz = 0; m_rest = 0; m_id = '0;
         return;
      end
      // a source is newly requested when its sample two edges ago was high
      // and the one before that was low
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = irq_in;
      op = m_pend; ph = m_phase; oen = m_en;
      m_rest = 1'b0;
      m_en   = cli ? 1'b0 : (sei ? 1'b1 : oen);
      m_pend = op | rise;
      case (ph)
         0: begin
            m_intr = 1'b0;
            if (oen && op != '0) begin m_phase = 1; m_intr = 1'b1; end
         end
         1: begin
            if (int_ack) begin
               i = 0;
               while (i < int'(N) - 1 && !op[i]) i++;
               m_id   = ID_W'(i);
               m_pend = (op & ~(N'(1) << i)) | rise;
               m_sc = c_in; m_sz = z_in; m_en = 1'b0; m_intr = 1'b0; m_phase = 2;
            end else if (cli) begin
               m_intr = 1'b0; m_phase = 0;
            end else begin
               m_intr = 1'b1;
            end
         end
         default: begin
            m_intr = 1'b0;
            if (retie) begin m_en = 1'b1; m_rest = 1'b1; m_phase = 0; end
         end
      endcase
   endtask

   // Advance n clock edges; inputs change and outputs are sampled on the falling edge.
   task automatic cycle(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(2);
      rst = 1'b0;
      checks++;
      if ({intr, int_en, src_id, pending, shad_c, shad_z, restore} !== VW'(0)) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {intr, int_en, src_id, pending, shad_c, shad_z, restore}, VW'(0));
      end
   endtask

   task automatic test_capture_ack();
      sei = 1'b1; cycle(); sei = 1'b0;
      checks++;
      if (int_en !== 1'b1) begin errors++; $display("FAIL t1_sei: got %b expected 1", int_en); end
      irq_in = 4'b0100;
      cycle(2);
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("FAIL t1_pend_early: got %b expected 0000", pending); end
      cycle();
      checks++;
      if ({pending, intr} !== {4'b0100, 1'b0}) begin
         errors++; $display("FAIL t1_pend_set: got %b expected %b", {pending, intr}, {4'b0100, 1'b0});
      end
      cycle();
      checks++;
      if (intr !== 1'b1) begin errors++; $display("FAIL t1_intr: got %b expected 1", intr); end
      c_in = 1'b1; z_in = 1'b0; int_ack = 1'b1;
      cycle();
      int_ack = 1'b0; c_in = 1'b0;
      checks++;
      if ({src_id, pending, shad_c, shad_z, int_en, intr} !== {2'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL t1_ack: got %b expected %b", {src_id, pending, shad_c, shad_z, int_en, intr},
                  {2'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
      end
   endtask

   task automatic test_retie();
      retie = 1'b1; cycle(); retie = 1'b0;
      checks++;
      if ({restore, int_en, intr} !== 3'b110) begin
         errors++; $display("FAIL t2_retie: got %b expected 110", {restore, int_en, intr});
      end
      cycle();
      checks++;
      if ({restore, intr} !== 2'b00) begin
         errors++; $display("FAIL t2_restore_pulse: got %b expected 00", {restore, intr});
      end
      cycle(4);
      checks++;
      if ({pending, intr, src_id, shad_c} !== {4'b0000, 1'b0, 2'd2, 1'b1}) begin
         errors++; $display("FAIL t2_held_level: got %b expected %b", {pending, intr, src_id, shad_c},
                            {4'b0000, 1'b0, 2'd2, 1'b1});
      end
   endtask

   task automatic test_priority();
      irq_in = 4'b1110;
      cycle(3);
      checks++;
      if (pending !== 4'b1010) begin errors++; $display("FAIL t3_pend: got %b expected 1010", pending); end
      cycle();
      int_ack = 1'b1; z_in = 1'b1; cycle(); int_ack = 1'b0; z_in = 1'b0;
      checks++;
      if ({src_id, pending, shad_z} !== {2'd1, 4'b1000, 1'b1}) begin
         errors++; $display("FAIL t3_ack1: got %b expected %b", {src_id, pending, shad_z}, {2'd1, 4'b1000, 1'b1});
      end
      retie = 1'b1; cycle(); retie = 1'b0;
      cycle();
      checks++;
      if (intr !== 1'b1) begin errors++; $display("FAIL t3_rereq: got %b expected 1", intr); end
      int_ack = 1'b1; cycle(); int_ack = 1'b0;
      checks++;
      if ({src_id, pending} !== {2'd3, 4'b0000}) begin
         errors++; $display("FAIL t3_ack2: got %b expected %b", {src_id, pending}, {2'd3, 4'b0000});
      end
      retie = 1'b1; cycle(); retie = 1'b0;
   endtask

   task automatic test_ignored();
      sei = 1'b1; cli = 1'b1; cycle(); sei = 1'b0; cli = 1'b0;
      checks++;
      if (int_en !== 1'b0) begin errors++; $display("FAIL t5_sei_cli: got %b expected 0", int_en); end
      int_ack = 1'b1; cycle(); int_ack = 1'b0;
      retie = 1'b1; cycle(); retie = 1'b0;
      checks++;
      if ({intr, restore, int_en, src_id, pending} !== {1'b0, 1'b0, 1'b0, 2'd3, 4'b0000}) begin
         errors++; $display("FAIL t5_idle_ignore: got %b expected %b", {intr, restore, int_en, src_id, pending},
                            {1'b0, 1'b0, 1'b0, 2'd3, 4'b0000});
      end
   endtask

   task automatic test_masked();
      irq_in = 4'b1111;
      cycle(5);
      checks++;
      if ({pending, intr} !== {4'b0001, 1'b0}) begin
         errors++; $display("FAIL t4_masked: got %b expected %b", {pending, intr}, {4'b0001, 1'b0});
      end
      sei = 1'b1; cycle(); sei = 1'b0;
      checks++;
      if (intr !== 1'b0) begin errors++; $display("FAIL t4_intr_early: got %b expected 0", intr); end
      cycle();
      checks++;
      if (intr !== 1'b1) begin errors++; $display("FAIL t4_intr: got %b expected 1", intr); end
      cli = 1'b1; cycle(); cli = 1'b0;
      checks++;
      if ({intr, int_en, pending} !== {1'b0, 1'b0, 4'b0001}) begin
         errors++; $display("FAIL t4_cli_req: got %b expected %b", {intr, int_en, pending}, {1'b0, 1'b0, 4'b0001});
      end
   endtask

   task automatic test_reset_mid_req();
      irq_in = 4'b1101; cycle(3);
      irq_in = 4'b1111; cycle(3);
      sei = 1'b1; cycle(); sei = 1'b0;
      cycle();
      checks++;
      if ({intr, pending} !== {1'b1, 4'b0011}) begin
         errors++; $display("FAIL t6_req: got %b expected %b", {intr, pending}, {1'b1, 4'b0011});
      end
      irq_in = '0; rst = 1'b1; int_ack = 1'b1; c_in = 1'b1; z_in = 1'b1;
      cycle();
      rst = 1'b0; int_ack = 1'b0; c_in = 1'b0; z_in = 1'b0;
      checks++;
      if ({intr, int_en, src_id, pending, shad_c, shad_z, restore} !== VW'(0)) begin
         errors++; $display("FAIL t6_reset: got %b expected %b",
                            {intr, int_en, src_id, pending, shad_c, shad_z, restore}, VW'(0));
      end
      cycle(3);
      irq_in = 4'b0001;
      cycle(3);
      checks++;
      if ({pending, intr} !== {4'b0001, 1'b0}) begin
         errors++; $display("FAIL t6_post_reset: got %b expected %b", {pending, intr}, {4'b0001, 1'b0});
      end
      cycle(2);
      checks++;
      if (intr !== 1'b0) begin errors++; $display("FAIL t6_masked: got %b expected 0", intr); end
   endtask

   task automatic test_collision();
      irq_in = '0; rst = 1'b1; cycle(); rst = 1'b0;
      sei = 1'b1; cycle(); sei = 1'b0;
      irq_in = 4'b0001; cycle();
      irq_in = 4'b0000; cycle();
      irq_in = 4'b0001; cycle();
      checks++;
      if (pending !== 4'b0001) begin errors++; $display("FAIL tc_pend: got %b expected 0001", pending); end
      cycle();
      int_ack = 1'b1; cycle(); int_ack = 1'b0;
      checks++;
      if ({src_id, pending, intr, int_en} !== {2'd0, 4'b0001, 1'b0, 1'b0}) begin
         errors++; $display("FAIL tc_set_wins: got %b expected %b", {src_id, pending, intr, int_en},
                            {2'd0, 4'b0001, 1'b0, 1'b0});
      end
      irq_in = '0;
      retie = 1'b1; cycle(); retie = 1'b0;
   endtask

   task automatic test_random();
      logic [VW-1:0] got, exp;
      rst = 1'b1; cycle(); rst = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         for (int b = 0; b < int'(N); b++)
            if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
         sei     = ($urandom_range(0, 5) == 0);
         cli     = ($urandom_range(0, 11) == 0);
         int_ack = ($urandom_range(0, 2) == 0);
         retie   = ($urandom_range(0, 4) == 0);
         c_in    = 1'($urandom);
         z_in    = 1'($urandom);
         rst     = ($urandom_range(0, 199) == 0);
         cycle();
         got = {intr, int_en, src_id, pending, shad_c, shad_z, restore};
         exp = {m_intr, m_en, m_id, m_pend, m_sc, m_sz, m_rest};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL rand_cycle_%0d: got %b expected %b", k, got, exp);
         end
      end
      sei = 0; cli = 0; int_ack = 0; retie = 0; rst = 0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_capture_ack();
      test_retie();
      test_priority();
      test_ignored();
      test_masked();
      test_reset_mid_req();
      test_collision();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller for the MCU; it sits between the external interrupt sources and the control unit.
- Synchronizes and edge-detects asynchronous requests and holds them as pending bits.
- Raises a single interrupt request to the CPU when interrupts are enabled, then completes the ack/return handshake with the control unit.
- Maintains the interrupt-enable flag and the shadow copies of the C/Z flags, saving them on ISR entry and presenting them for restore on RETIE.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..8).
- ID_W, $clog2(NUM_SRC) (min 1), width of the source-ID output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  NUM_SRC  asynchronous external requests, rising-edge sensitive.
- sei  input  1  one-cycle pulse from control unit: set interrupt enable.
- cli  input  1  one-cycle pulse from control unit: clear interrupt enable.
- int_ack  input  1  one-cycle pulse: CPU has vectored into the ISR.
- retie  input  1  one-cycle pulse: CPU executed return-from-interrupt.
- c_in  input  1  current C flag.
- z_in  input  1  current Z flag.
- intr  output  1  interrupt request to control unit (registered).
- int_en  output  1  interrupt enable flag.
- src_id  output  ID_W  ID of the source being serviced (valid in IN_ISR).
- pending  output  NUM_SRC  latched pending requests.
- shad_c  output  1  saved C flag.
- shad_z  output  1  saved Z flag.
- restore  output  1  one-cycle pulse; the control unit loads C/Z from shad_c/shad_z.

Behaviour:
- Reset:
  - Clears all outputs, synchronizer/edge flops, the pending bits and the state register; state goes to IDLE.
  - Takes effect on the next edge regardless of current state, including mid-ISR.
- Input capture:
  - Each irq_in bit passes through 2 flops plus a previous-value flop.
  - edge[i] = sync2[i] & ~prev[i].
  - pending[i] sets on the 3rd rising edge after irq_in[i] first samples high.
  - A level held high produces exactly one edge; it must fall and rise again to re-request.
- Enable flag:
  - cli clears int_en and has priority over sei when both are asserted.
  - sei sets int_en; with neither asserted, int_en holds.
- State IDLE:
  - intr=0.
  - If int_en=1 and pending!=0, go to REQ next edge; intr=1 from that edge.
- State REQ:
  - intr=1.
  - On int_ack:
    - src_id <= lowest-index set pending bit (fixed priority, bit 0 highest).
    - That pending bit clears.
    - shad_c<=c_in, shad_z<=z_in.
    - int_en<=0 (hardware mask).
    - intr<=0; go to IN_ISR.
  - If cli is asserted (without int_ack): intr<=0, go to IDLE; pending is retained.
  - If int_ack and cli coincide: the ack is taken; int_en ends at 0.
- State IN_ISR:
  - intr=0; new edges still set pending.
  - sei/cli in this state modify int_en normally.
  - On retie: int_en<=1, restore=1 for exactly one cycle, go to IDLE.
  - Pending requests are then re-evaluated from IDLE; the earliest re-request is 2 edges after retie.
- Ignored inputs:
  - int_ack is ignored outside REQ.
  - retie is ignored outside IN_ISR; restore stays 0.
- Simultaneous events:
  - If an edge arrives on the same bit being cleared by int_ack, the set wins and the bit remains pending.
  - Edges on other bits always set.
- Hold rules:
  - shad_c/shad_z and src_id hold their values until the next int_ack.
- Encoding:
  - src_id is zero-extended.
  - The state register holds no illegal states; unused encodings go to IDLE.

Test Plan:
1. Reset, then sei; pulse irq_in[2] high and hold → pending=0100 three edges after first sample; intr=1 one edge later; int_ack with c_in=1, z_in=0 → src_id=2, pending=0000, shad_c=1, shad_z=0, int_en=0, intr=0.
2. From IN_ISR, retie → restore high for exactly 1 cycle, int_en=1, state IDLE; with irq_in[2] still held high → no new request (pending stays 0000).
3. Raise irq_in[3] and irq_in[1] in the same cycle with int_en=1; int_ack → src_id=1, pending=1000; after retie, intr reasserts; next int_ack → src_id=3.
4. int_en=0 and irq_in[0] rises → pending=0001, intr stays 0; sei → intr=1 two edges later; cli while in REQ → intr=0 next edge, pending=0001 retained.
5. sei and cli pulsed together → int_en=0; int_ack or retie pulsed in IDLE → no state change, restore=0.
6. In REQ with pending=0011, assert rst together with int_ack → all outputs 0, state IDLE, shad_c/shad_z=0; a new irq_in[0] edge after reset with int_en=0 sets pending but intr stays 0.
